add_seq: RTL
============

# add_seq

Parametrised, digit-serial signed/unsigned adder-subtractor; the multi-cycle successor of the 16-bit ripple `add`. It accepts one operation per handshake and processes DIGIT bits per clock, low digit first, through a DIGIT-wide `full_add` chain. It reports carry, overflow, zero and negative flags, with optional signed saturation, and sits in the datapath wherever area matters more than single-cycle latency.

## Interface
- `WIDTH`, 16: operand and result width; must be a multiple of DIGIT.
- `DIGIT`, 4: bits processed per cycle, 1..WIDTH; NDIG = WIDTH/DIGIT.
- `SAT`, 0: 1 = clamp signed overflow to the most-positive/most-negative value.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands/op valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`, `b`  in  WIDTH  operands.
- `op`  in  2  00 ADD a+b; 01 SUB a+~b+1; 10 ADC a+b+carry_in; 11 SBB a+~b+carry_in (carry_in=1 means no borrow).
- `carry_in`  in  1  used by ADC/SBB only.
- `abort`  in  1  synchronous cancel of an operation in RUN.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out`  out  WIDTH  result, saturated when SAT=1 and overflow.
- `carry_out`, `overflow`, `zero`, `neg`  out  1 each  flags.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b^{WIDTH{invert}}, and the initial carry, then go to RUN. invert=op[0]. Initial carry = 0 for ADD, 1 for SUB, carry_in for ADC/SBB.
- RUN: each edge adds the low DIGIT bits of the operand shift registers plus the carry register. The sum digit is shifted into the result register from the top. The carry register takes the digit carry-out. The zero accumulator ORs in the sum digit. A digit counter counts 0..NDIG-1.
- On the last digit, capture carry into bit WIDTH-1 and carry out of bit WIDTH-1. overflow = XOR of the two; carry_out = carry out of the MSB. Then go to DONE.
- Raw carry_out is reported for SUB/SBB too: 1 = no borrow.
- SAT=1 and overflow=1: out = 0x7F..F if latched a[MSB]=0, else 0x80..0. Flags other than zero/neg remain raw.
- zero = (out==0) and neg = out[MSB], both evaluated on the final, possibly saturated, out.
- DONE: out_valid=1, outputs held stable. On out_ready go to IDLE.
- abort in RUN: next edge goes to IDLE, out_valid never asserts, and the result is discarded. abort is ignored in IDLE and DONE.
- abort and completion on the same edge: abort wins.
- Reset values: state IDLE, in_ready=1 once reset deasserts, out_valid=0, out=0, all flags 0, all internal registers 0.
- Reset mid-RUN or mid-DONE: immediate return to IDLE and the operation is lost.

## Timing
- Acceptance edge T. Digits are computed on edges T+1..T+NDIG. out_valid is high from just after edge T+NDIG.
- Latency NDIG cycles. DIGIT=WIDTH gives a single RUN cycle.
- in_ready is low from T until the edge after the out handshake. Maximum throughput is one operation per NDIG+2 cycles.
- out and the flags are registered and change only on entry to DONE or on reset.
- in_ready depends only on state; there is no combinational path from out_ready to in_ready.

## Structure
- Shared package holds the op encoding constants (OP_ADD, OP_SUB, OP_ADC, OP_SBB) and the state enum.
- Sub-module `add_digit`: a DIGIT-wide ripple of `full_add` instances with ports sum, carry_out, carry into the top bit (for overflow), a, b, carry_in.
- Top level holds the FSM, shift registers, counter, flag and saturation logic.

## Test plan
Defaults WIDTH=16, DIGIT=4:
- ADD 0x7FFF+0x0001 -> out 0x8000, overflow=1, carry_out=0, neg=1, zero=0. With SAT=1 -> out 0x7FFF, overflow=1.
- SUB 0x8000-0x0001 -> out 0x7FFF, overflow=1, carry_out=1. SUB 0x0000-0x0001 -> out 0xFFFF, carry_out=0, overflow=0. With SAT=1, the first case -> out 0x8000.
- ADC 0xFFFF+0x0000, carry_in=1 -> out 0x0000, carry_out=1, zero=1, overflow=0. SBB 0x0005-0x0003, carry_in=0 -> out 0x0001.
- Accept at edge T -> out_valid first high after T+4. Hold out_ready=0 for 10 cycles -> out/flags stable, in_ready=0. Release -> in_ready=1 the next cycle.
- abort asserted at the second RUN edge -> no out_valid, in_ready=1 the next cycle. rst_n pulsed low mid-RUN -> outputs 0 asynchronously and the next operation is correct.
- Configurations DIGIT=1, DIGIT=16, and WIDTH=32/DIGIT=8: 1000 random operands over all ops, compared against a reference model including flags and latency NDIG.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared definitions for the digit-serial adder-subtractor: op encodings,
// FSM state type and the initial-carry rule.
`timescale 1ns/1ps
package add_seq_pkg;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBB = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // SUB folds its +1 into the carry; ADC/SBB take it from the caller.
   function automatic logic init_carry(input logic [1:0] op, input logic cin);
      case (op)
         OP_ADD:  return 1'b0;
         OP_SUB:  return 1'b1;
         default: return cin;
      endcase
   endfunction
endpackage

// File: rtl/add_seq_digit.sv
// One-bit full adder and the DIGIT-wide ripple built from it; the carry into
// the top bit is exported so the caller can form signed overflow.
`timescale 1ns/1ps
module full_add (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_digit #(
   parameter int DIGIT = 4
) (
   output logic [DIGIT-1:0] sum,
   output logic             carry_out,
   output logic             carry_top,
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             carry_in
);
   logic [DIGIT:0] w_c;

   assign w_c[0] = carry_in;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      full_add u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (w_c[i]),
         .s  (sum[i]),
         .co (w_c[i+1])
      );
   end

   assign carry_out = w_c[DIGIT];
   assign carry_top = w_c[DIGIT-1];
endmodule

// File: rtl/add_seq.sv
// Digit-serial add/sub with carry, overflow, zero and negative flags and
// optional signed saturation; one operation per in/out handshake pair.
`timescale 1ns/1ps
module add_seq
   import add_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             carry_in,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             neg
);
   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t r_state, w_next;

   logic [WIDTH-1:0] r_a, r_b, r_res;
   logic             r_carry, r_zacc, r_amsb;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] r_out;
   logic             r_cout, r_ovf, r_zero, r_neg;

   logic [DIGIT-1:0]       w_sum;
   logic                   w_dcout, w_ctop, w_last, w_ovf, w_sat_hit, w_zero;
   logic [WIDTH+DIGIT-1:0] w_cat;
   logic [WIDTH-1:0]       w_res_next, w_final;

   function automatic logic [WIDTH-1:0] sat_value(input logic amsb);
      return amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   add_digit #(.DIGIT(DIGIT)) u_digit (
      .sum       (w_sum),
      .carry_out (w_dcout),
      .carry_top (w_ctop),
      .a         (r_a[DIGIT-1:0]),
      .b         (r_b[DIGIT-1:0]),
      .carry_in  (r_carry)
   );

   // Sum digits enter from the top so the low digit ends at bit 0 after NDIG shifts.
   assign w_cat      = {w_sum, r_res};
   assign w_res_next = w_cat[WIDTH+DIGIT-1:DIGIT];
   assign w_last     = (r_cnt == CNT_W'(NDIG - 1));
   assign w_ovf      = w_dcout ^ w_ctop;
   assign w_sat_hit  = SAT && w_ovf;
   assign w_final    = w_sat_hit ? sat_value(r_amsb) : w_res_next;
   assign w_zero     = !w_sat_hit && !(r_zacc || (|w_sum));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = S_RUN;
         S_RUN: begin
            if (abort)       w_next = S_IDLE;
            else if (w_last) w_next = S_DONE;
         end
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_zacc  <= 1'b0;
         r_amsb  <= 1'b0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b ^ {WIDTH{op[0]}};
                  r_carry <= init_carry(op, carry_in);
                  r_amsb  <= a[WIDTH-1];
                  r_cnt   <= '0;
                  r_zacc  <= 1'b0;
                  r_res   <= '0;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_res   <= w_res_next;
               r_carry <= w_dcout;
               r_zacc  <= r_zacc | (|w_sum);
               r_cnt   <= r_cnt + CNT_W'(1);
               // Abort wins over completion: results are only published on DONE entry.
               if (w_last && !abort) begin
                  r_out  <= w_final;
                  r_cout <= w_dcout;
                  r_ovf  <= w_ovf;
                  r_zero <= w_zero;
                  r_neg  <= w_final[WIDTH-1];
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign out       = r_out;
   assign carry_out = r_cout;
   assign overflow  = r_ovf;
   assign zero      = r_zero;
   assign neg       = r_neg;
endmodule
